mmio_io_ctrl: RTL and testbench
===============================

// Module: mmio_io_ctrl
// PURPOSE
//  Memory-mapped I/O controller for the 0x8xxxxxxx region. Replaces the pipeline's
//  combinational UART and counter decode with a registered, parametrised block.
//  Request enters in E; read data returns registered in M. Contains:
//  - TX holding register and RX buffer with valid/ready handshakes to the UART.
//  - NUM_CNT event counters plus a counter-clear register.
// PARAMETERS
//  DATA_W   32  bus data width
//  NUM_CNT  2   number of event counters (2 = legacy cycle/instr map)
//  CNT_W    32  counter width (<= DATA_W)
//  RX_DEPTH 4   RX FIFO depth, power of 2 (used only with MMIO_RX_FIFO_EN)
// PORTS
//  clk        in  1         clock
//  reset_n    in  1         synchronous reset, active-low
//  stall      in  1         pipeline stall; no access is taken while high
//  addrE      in  32        byte address (ALU result, E stage)
//  reE        in  1         load in E
//  weE        in  4         store byte enables in E
//  wdataE     in  DATA_W    store data
//  rdataM     out DATA_W    registered read data (M stage)
//  errM       out 1         registered 1-cycle pulse: bad MMIO access
//  cnt_inc    in  NUM_CNT   per-counter increment strobes
//  tx_data    out 8         UART transmit byte
//  tx_valid   out 1         TX byte available
//  tx_ready   in  1         UART accepts TX byte
//  rx_data    in  8         UART receive byte
//  rx_valid   in  1         UART RX byte available
//  rx_ready   out 1         buffer can accept an RX byte
// BEHAVIOUR
//  - Access: acc = (addrE[31:28]==4'h8) & (reE | |weE) & ~stall. Offset is addrE[7:0].
//    addrE[27:8] is ignored.
//  - Map:
//    0x00 R   TX status: {..., tx_ovf, ~tx_full}
//    0x04 W   TX data: wdataE[7:0]; needs weE[0]
//    0x08 R   RX status: bit0 = rx not empty
//    0x0C R   RX data: zero-extended; pops one entry
//    0x10+4i R counter i, for i < NUM_CNT
//    0x10+4*NUM_CNT W  write any value to clear all counters
//  - Latency: rdataM and errM update on the edge after acc. Without acc, rdataM = 0.
//  - errM = 1 for any of:
//    - unmapped offset
//    - write to a read-only offset
//    - read of a write-only offset
//    - store to 0x04 with weE[0]=0
//    Erroneous reads return 0.
//  - TX path:
//    - Write is accepted only if tx_full is 0 at that edge (registered state).
//    - Write while full is dropped and sets sticky tx_ovf; a read of 0x00 clears tx_ovf.
//    - tx_valid = tx_full. Handshake (tx_valid & tx_ready) clears tx_full.
//    - Handshake and write in the same cycle while full: drain happens, write dropped,
//      tx_ovf set.
//  - RX path:
//    - rx_ready = ~rx_full & reset_n. Push on rx_valid & rx_ready.
//    - Pushed byte is readable from the next cycle.
//    - Read of 0x0C when empty returns 0, does not pop, and is not an error.
//    - Push and pop in the same cycle when non-empty and non-full: both occur, count unchanged.
//    - When full, the pop proceeds and the push is blocked by rx_ready=0.
//  - Counters:
//    - cnt[i] increments on cnt_inc[i] and wraps from 2^CNT_W-1 to 0.
//    - A read returns the value before that edge's increment, zero-extended.
//    - Clear and increment in the same cycle: result is 0.
//  - Stall: no state changes from the request (pops, writes, clears, status reads).
//    Counters and the UART handshakes keep running.
//  - Reset (reset_n=0 at edge): rdataM=0, errM=0, tx_valid=0, tx_data=0, tx_ovf=0,
//    RX buffer empty, counters=0. rx_ready=0 while reset_n is low.
//    Reset mid-transfer drops any buffered TX/RX byte.
// CONFIGURATION
//  MMIO_RX_FIFO_EN defined: RX buffer is an RX_DEPTH-entry FIFO (mmio_rx_fifo).
//    rx_full = (count==RX_DEPTH); pointers wrap modulo RX_DEPTH.
//  Undefined: single-entry RX register. rx_full = valid bit. RX_DEPTH is ignored.
// STRUCTURE
//  - Shared header MMIO.vh holds:
//    MMIO_REGION (4'h8), the offsets (TX_STAT, TX_DATA, RX_STAT, RX_DATA, CNT_BASE),
//    and the status bit positions.
//  - One sub-module: mmio_rx_fifo (param WIDTH, DEPTH) with push/pop/empty/full/rdata,
//    instantiated only under MMIO_RX_FIFO_EN.
//  - Decode, TX register, counters and read mux live in mmio_io_ctrl.
// TESTING
//  1. Load 0x80000000 idle -> rdataM=0x1. Store 0x41 to 0x80000004 -> tx_valid=1, tx_data=0x41.
//     Hold tx_ready=0 and store 0x42 -> dropped, read 0x00 = 0x2. Assert tx_ready one cycle
//     -> tx_valid=0. Reread 0x00 -> 0x1.
//  2. rx_valid with 0x5A -> next cycle 0x08 reads 0x1, 0x0C reads 0x5A, then 0x08 reads 0x0.
//     A second 0x0C read returns 0, errM=0.
//  3. With MMIO_RX_FIFO_EN and RX_DEPTH=4, push 5 bytes -> rx_ready=0 after 4.
//     Reads return bytes 1..4 in order; byte 5 is accepted after the first pop.
//  4. cnt_inc=2'b01 for 100 cycles -> 0x10 reads 100, 0x14 reads 0. Store to 0x18 with
//     cnt_inc high -> next 0x10 read is 0. With CNT_W=8, 256 increments -> 0 (wrap).
//  5. Load 0x80000004 -> errM pulse, rdataM=0. Store to 0x80000010 -> errM, counter unchanged.
//     Load 0x800000F0 -> errM.
//  6. stall=1 during a 0x0C load -> no pop, rdataM=0. Pulse reset_n=0 with TX and RX
//     buffers full -> tx_valid=0, rx buffer empty, counters 0.

Source files
------------

// File: rtl/mmio_io_ctrl_pkg.sv
// Shared constants for the MMIO controller: region nibble, register offsets, status bit positions.
package mmio_io_ctrl_pkg;

  localparam logic [3:0] MMIO_REGION = 4'h8;

  localparam logic [7:0] TX_STAT  = 8'h00;
  localparam logic [7:0] TX_DATA  = 8'h04;
  localparam logic [7:0] RX_STAT  = 8'h08;
  localparam logic [7:0] RX_DATA  = 8'h0C;
  localparam logic [7:0] CNT_BASE = 8'h10;

  localparam int TX_RDY_BIT = 0;
  localparam int TX_OVF_BIT = 1;
  localparam int RX_NE_BIT  = 0;

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_TX_STAT,
    TGT_TX_DATA,
    TGT_RX_STAT,
    TGT_RX_DATA,
    TGT_CNT,
    TGT_CLR
  } tgt_e;

  // Offset of counter idx; idx == NUM_CNT gives the clear register.
  function automatic logic [7:0] cnt_offset(input int idx);
    return CNT_BASE + 8'(4 * idx);
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_rx_fifo.sv
// mmio_rx_fifo: small power-of-two FIFO used as the RX buffer when MMIO_RX_FIFO_EN is defined.
module mmio_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Registered MMIO controller for the 0x8xxxxxxx region: UART TX/RX buffers and event counters.
// Define MMIO_RX_FIFO_EN to replace the single-entry RX register with an RX_DEPTH-entry FIFO.
module mmio_io_ctrl
  import mmio_io_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_CNT  = 2,
  parameter int CNT_W    = 32,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic [31:0]       addrE,
  input  logic              reE,
  input  logic [3:0]        weE,
  input  logic [DATA_W-1:0] wdataE,
  output logic [DATA_W-1:0] rdataM,
  output logic              errM,
  input  logic [NUM_CNT-1:0] cnt_inc,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int CSW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  logic [7:0]        off;
  logic              is_wr, is_rd, acc, err;
  logic              ok_rd, ok_wr;
  tgt_e              tgt;
  logic [CSW-1:0]    cnt_sel;
  logic [DATA_W-1:0] rd_next;
  logic              tx_full, tx_ovf, tx_wr, tx_hs, stat_rd;
  logic              rx_empty, rx_full, rx_push, rx_pop;
  logic [7:0]        rx_head;
  logic              cnt_clr;
  logic [CNT_W-1:0]  cnt [NUM_CNT];
  logic              unused_bits;

  assign off   = addrE[7:0];
  assign is_wr = |weE;
  assign is_rd = reE & ~is_wr;
  assign acc   = (addrE[31:28] == MMIO_REGION) & (reE | is_wr) & ~stall;
  assign unused_bits = ^{addrE[27:8], wdataE};

  always_comb begin
    tgt     = TGT_NONE;
    cnt_sel = '0;
    case (off)
      TX_STAT: tgt = TGT_TX_STAT;
      TX_DATA: tgt = TGT_TX_DATA;
      RX_STAT: tgt = TGT_RX_STAT;
      RX_DATA: tgt = TGT_RX_DATA;
      default: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (off == cnt_offset(i)) begin
            tgt     = TGT_CNT;
            cnt_sel = CSW'(i);
          end
        end
        if (off == cnt_offset(NUM_CNT)) tgt = TGT_CLR;
      end
    endcase
  end

  // Direction checks: wrong-direction access or a TX store without the low byte lane is an error.
  always_comb begin
    err = 1'b0;
    case (tgt)
      TGT_NONE:    err = 1'b1;
      TGT_TX_DATA: err = is_rd | ~weE[0];
      TGT_CLR:     err = is_rd;
      default:     err = is_wr;
    endcase
  end

  assign ok_rd   = acc & ~err & is_rd;
  assign ok_wr   = acc & ~err & is_wr;
  assign tx_wr   = ok_wr & (tgt == TGT_TX_DATA);
  assign tx_hs   = tx_full & tx_ready;
  assign stat_rd = ok_rd & (tgt == TGT_TX_STAT);
  assign rx_push = rx_valid & rx_ready;
  assign rx_pop  = ok_rd & (tgt == TGT_RX_DATA) & ~rx_empty;
  assign cnt_clr = ok_wr & (tgt == TGT_CLR);
  assign tx_valid = tx_full;
  assign rx_ready = ~rx_full & reset_n;

  always_comb begin
    rd_next = '0;
    if (ok_rd) begin
      case (tgt)
        TGT_TX_STAT: begin
          rd_next[TX_RDY_BIT] = ~tx_full;
          rd_next[TX_OVF_BIT] = tx_ovf;
        end
        TGT_RX_STAT: rd_next[RX_NE_BIT] = ~rx_empty;
        TGT_RX_DATA: if (!rx_empty) rd_next[7:0] = rx_head;
        TGT_CNT:     rd_next[CNT_W-1:0] = cnt[cnt_sel];
        default:     rd_next = '0;
      endcase
    end
  end

  // A store while full is dropped even if the UART drains in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdataM  <= '0;
      errM    <= 1'b0;
      tx_full <= 1'b0;
      tx_data <= '0;
      tx_ovf  <= 1'b0;
    end else begin
      rdataM <= rd_next;
      errM   <= acc & err;
      if (tx_wr && !tx_full) begin
        tx_full <= 1'b1;
        tx_data <= wdataE[7:0];
      end else if (tx_hs) begin
        tx_full <= 1'b0;
      end
      if (tx_wr && tx_full) tx_ovf <= 1'b1;
      else if (stat_rd)     tx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (!reset_n || cnt_clr) cnt[i] <= '0;
      else if (cnt_inc[i])     cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

`ifdef MMIO_RX_FIFO_EN
  mmio_rx_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_push),
    .pop     (rx_pop),
    .wdata   (rx_data),
    .rdata   (rx_head),
    .empty   (rx_empty),
    .full    (rx_full)
  );
`else
  localparam int unused_rx_depth = RX_DEPTH;
  logic       rx_vld;
  logic [7:0] rx_byte;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_vld  <= 1'b0;
      rx_byte <= '0;
    end else if (rx_push) begin
      rx_vld  <= 1'b1;
      rx_byte <= rx_data;
    end else if (rx_pop) begin
      rx_vld  <= 1'b0;
    end
  end

  assign rx_empty = ~rx_vld;
  assign rx_full  = rx_vld;
  assign rx_head  = rx_byte;
`endif

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl; a second instance with CNT_W=8 covers counter wrap.
module tb_mmio_io_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic [31:0] addrE;
  logic        reE;
  logic [3:0]  weE;
  logic [31:0] wdataE;
  logic [1:0]  cnt_inc;
  logic [1:0]  cnt_inc8;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic [31:0] rdataM, rdataM_8;
  logic        errM, errM_8;
  logic [7:0]  tx_data, tx_data_8;
  logic        tx_valid, tx_valid_8;
  logic        rx_ready, rx_ready_8;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mmio_io_ctrl dut (
    .clk (clk), .reset_n (reset_n), .stall (stall),
    .addrE (addrE), .reE (reE), .weE (weE), .wdataE (wdataE),
    .rdataM (rdataM), .errM (errM), .cnt_inc (cnt_inc),
    .tx_data (tx_data), .tx_valid (tx_valid), .tx_ready (tx_ready),
    .rx_data (rx_data), .rx_valid (rx_valid), .rx_ready (rx_ready)
  );

  mmio_io_ctrl #(.CNT_W (8)) dut8 (
    .clk (clk), .reset_n (reset_n), .stall (stall),
    .addrE (addrE), .reE (reE), .weE (weE), .wdataE (wdataE),
    .rdataM (rdataM_8), .errM (errM_8), .cnt_inc (cnt_inc8),
    .tx_data (tx_data_8), .tx_valid (tx_valid_8), .tx_ready (tx_ready),
    .rx_data (rx_data), .rx_valid (rx_valid), .rx_ready (rx_ready_8)
  );

  // One bus access: drive for one edge, return #1 after it so M-stage outputs are settled.
  task automatic applyStimulus(input logic [31:0] addr, input logic re,
                               input logic [3:0] we, input logic [31:0] wd);
    addrE  = addr;
    reE    = re;
    weE    = we;
    wdataE = wd;
    @(posedge clk);
    #1;
    addrE  = '0;
    reE    = 1'b0;
    weE    = '0;
    wdataE = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    stall    = 1'b0;
    addrE    = '0;
    reE      = 1'b0;
    weE      = '0;
    wdataE   = '0;
    cnt_inc  = '0;
    cnt_inc8 = '0;
    tx_ready = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;

    idle(2);
    checkOutput("rst_rdata", rdataM, 32'h0);
    checkOutput("rst_err", {31'b0, errM}, 32'h0);
    checkOutput("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    checkOutput("rst_tx_data", {24'b0, tx_data}, 32'h0);
    checkOutput("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
    reset_n = 1'b1;
    #1;
    checkOutput("rx_ready_up", {31'b0, rx_ready}, 32'h1);

    // TX path
    applyStimulus(32'h8000_0000, 1'b1, 4'h0, 32'h0);
    checkOutput("tx_stat_idle", rdataM, 32'h1);
    checkOutput("tx_stat_idle_err", {31'b0, errM}, 32'h0);
    applyStimulus(32'h8000_0004, 1'b0, 4'h1, 32'h41);
    checkOutput("tx_valid_set", {31'b0, tx_valid}, 32'h1);
    checkOutput("tx_data_41", {24'b0, tx_data}, 32'h41);
    checkOutput("tx_wr_err", {31'b0, errM}, 32'h0);
    applyStimulus(32'h8000_0004, 1'b0, 4'h1, 32'h42);
    checkOutput("tx_drop_keep", {24'b0, tx_data}, 32'h41);
    applyStimulus(32'h8000_0000, 1'b1, 4'h0, 32'h0);
    checkOutput("tx_stat_ovf", rdataM, 32'h2);
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    checkOutput("tx_drained", {31'b0, tx_valid}, 32'h0);
    applyStimulus(32'h8000_0000, 1'b1, 4'h0, 32'h0);
    checkOutput("tx_stat_clr", rdataM, 32'h1);

    // RX path
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    idle(1);
    rx_valid = 1'b0;
`ifndef MMIO_RX_FIFO_EN
    checkOutput("rx_full_ready", {31'b0, rx_ready}, 32'h0);
`endif
    applyStimulus(32'h8000_0008, 1'b1, 4'h0, 32'h0);
    checkOutput("rx_stat_ne", rdataM, 32'h1);
    applyStimulus(32'h8000_000C, 1'b1, 4'h0, 32'h0);
    checkOutput("rx_data_5a", rdataM, 32'h5A);
    checkOutput("rx_ready_back", {31'b0, rx_ready}, 32'h1);
    applyStimulus(32'h8000_0008, 1'b1, 4'h0, 32'h0);
    checkOutput("rx_stat_empty", rdataM, 32'h0);
    applyStimulus(32'h8000_000C, 1'b1, 4'h0, 32'h0);
    checkOutput("rx_empty_read", rdataM, 32'h0);
    checkOutput("rx_empty_err", {31'b0, errM}, 32'h0);

`ifdef MMIO_RX_FIFO_EN
    rx_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      rx_data = 8'(k);
      idle(1);
    end
    rx_data = 8'd5;
    checkOutput("fifo_full_ready", {31'b0, rx_ready}, 32'h0);
    applyStimulus(32'h8000_000C, 1'b1, 4'h0, 32'h0);
    checkOutput("fifo_b1", rdataM, 32'h1);
    checkOutput("fifo_ready_pop", {31'b0, rx_ready}, 32'h1);
    applyStimulus(32'h8000_000C, 1'b1, 4'h0, 32'h0);
    rx_valid = 1'b0;
    checkOutput("fifo_b2", rdataM, 32'h2);
    for (int k = 3; k <= 5; k++) begin
      applyStimulus(32'h8000_000C, 1'b1, 4'h0, 32'h0);
      checkOutput("fifo_bn", rdataM, 32'(k));
    end
    applyStimulus(32'h8000_0008, 1'b1, 4'h0, 32'h0);
    checkOutput("fifo_empty", rdataM, 32'h0);
`endif

    // Counters
    cnt_inc = 2'b01;
    idle(100);
    cnt_inc = 2'b00;
    applyStimulus(32'h8000_0010, 1'b1, 4'h0, 32'h0);
    checkOutput("cnt0_100", rdataM, 32'd100);
    applyStimulus(32'h8000_0014, 1'b1, 4'h0, 32'h0);
    checkOutput("cnt1_0", rdataM, 32'd0);
    cnt_inc = 2'b01;
    applyStimulus(32'h8000_0018, 1'b0, 4'hF, 32'h1234);
    cnt_inc = 2'b00;
    checkOutput("cnt_clr_err", {31'b0, errM}, 32'h0);
    applyStimulus(32'h8000_0010, 1'b1, 4'h0, 32'h0);
    checkOutput("cnt0_cleared", rdataM, 32'd0);
    cnt_inc = 2'b01;
    applyStimulus(32'h8000_0010, 1'b1, 4'h0, 32'h0);
    cnt_inc = 2'b00;
    checkOutput("cnt0_pre_inc", rdataM, 32'd0);
    applyStimulus(32'h8000_0010, 1'b1, 4'h0, 32'h0);
    checkOutput("cnt0_post_inc", rdataM, 32'd1);
    cnt_inc8 = 2'b01;
    idle(255);
    cnt_inc8 = 2'b00;
    applyStimulus(32'h8000_0010, 1'b1, 4'h0, 32'h0);
    checkOutput("cnt8_ff", rdataM_8, 32'hFF);
    cnt_inc8 = 2'b01;
    idle(1);
    cnt_inc8 = 2'b00;
    applyStimulus(32'h8000_0010, 1'b1, 4'h0, 32'h0);
    checkOutput("cnt8_wrap", rdataM_8, 32'h0);

    // Error cases
    applyStimulus(32'h8000_0004, 1'b1, 4'h0, 32'h0);
    checkOutput("err_rd_wo", {31'b0, errM}, 32'h1);
    checkOutput("err_rd_wo_data", rdataM, 32'h0);
    idle(1);
    checkOutput("err_pulse_end", {31'b0, errM}, 32'h0);
    applyStimulus(32'h8000_0010, 1'b0, 4'hF, 32'hFFFF);
    checkOutput("err_wr_ro", {31'b0, errM}, 32'h1);
    applyStimulus(32'h8000_0010, 1'b1, 4'h0, 32'h0);
    checkOutput("cnt0_unchanged", rdataM, 32'd1);
    applyStimulus(32'h8000_00F0, 1'b1, 4'h0, 32'h0);
    checkOutput("err_unmapped", {31'b0, errM}, 32'h1);
    applyStimulus(32'h8000_0004, 1'b0, 4'h2, 32'h6600);
    checkOutput("err_tx_lane", {31'b0, errM}, 32'h1);
    checkOutput("err_tx_lane_nowr", {31'b0, tx_valid}, 32'h0);
    applyStimulus(32'h8000_001C, 1'b1, 4'h0, 32'h0);
    checkOutput("err_cnt_oob", {31'b0, errM}, 32'h1);
    applyStimulus(32'h4000_0000, 1'b1, 4'h0, 32'h0);
    checkOutput("nonregion_err", {31'b0, errM}, 32'h0);
    checkOutput("nonregion_data", rdataM, 32'h0);
    applyStimulus(32'h8ABC_DE00, 1'b1, 4'h0, 32'h0);
    checkOutput("alias_tx_stat", rdataM, 32'h1);

    // Stall and reset with buffers loaded
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    idle(1);
    rx_valid = 1'b0;
    applyStimulus(32'h8000_0008, 1'b1, 4'h0, 32'h0);
    checkOutput("rx_stat_pre_stall", rdataM, 32'h1);
    stall = 1'b1;
    applyStimulus(32'h8000_000C, 1'b1, 4'h0, 32'h0);
    stall = 1'b0;
    checkOutput("stall_rdata", rdataM, 32'h0);
    checkOutput("stall_err", {31'b0, errM}, 32'h0);
    applyStimulus(32'h8000_0008, 1'b1, 4'h0, 32'h0);
    checkOutput("stall_no_pop", rdataM, 32'h1);
    applyStimulus(32'h8000_0004, 1'b0, 4'h1, 32'h33);
    checkOutput("tx_loaded", {31'b0, tx_valid}, 32'h1);
    cnt_inc = 2'b11;
    idle(3);
    cnt_inc = 2'b00;
    reset_n = 1'b0;
    idle(1);
    checkOutput("rst2_tx_valid", {31'b0, tx_valid}, 32'h0);
    checkOutput("rst2_tx_data", {24'b0, tx_data}, 32'h0);
    checkOutput("rst2_rx_ready", {31'b0, rx_ready}, 32'h0);
    reset_n = 1'b1;
    applyStimulus(32'h8000_0008, 1'b1, 4'h0, 32'h0);
    checkOutput("rst2_rx_empty", rdataM, 32'h0);
    applyStimulus(32'h8000_0010, 1'b1, 4'h0, 32'h0);
    checkOutput("rst2_cnt0", rdataM, 32'h0);
    applyStimulus(32'h8000_0014, 1'b1, 4'h0, 32'h0);
    checkOutput("rst2_cnt1", rdataM, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
